// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between a value producer and the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic                    load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed BCD digit scanner: digit_en/bcd_out registered one cycle behind the FSM decision;
// loads double-buffered so a new value only reaches the display on a frame boundary or disable.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 1000,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_en,
  input  logic                  blank_lz,
  seg_scan_ctrl_if.slave        load_if,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {OFF, SHOW, GAP} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  act_vld_q, act_vld_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;

  logic          last_digit;
  logic          boundary;
  logic          load_fire;
  logic          transfer;
  logic [IW-1:0] next_idx;
  logic [3:0]    nib;
  logic          upper_zero;

  // The frame ends in the last cycle of the final digit's gap, or of its show phase when there is no gap.
  assign last_digit = (idx_q == IDX_LAST);
  assign boundary   = (GAP_CYCLES > 0) ? (last_digit && state_q == GAP  && cnt_q == GAP_LAST)
                                       : (last_digit && state_q == SHOW && cnt_q == SHOW_LAST);
  assign next_idx   = last_digit ? '0 : idx_q + IW'(1);

  assign load_if.load_ready = (state_q == OFF) || !pend_vld_q || boundary;
  assign load_fire          = load_if.load_valid && load_if.load_ready;
  assign transfer           = (state_q != OFF) && pend_vld_q && (boundary || !disp_en);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      OFF: begin
        idx_d = '0;
        cnt_d = '0;
        if (disp_en && act_vld_q) state_d = SHOW;
      end
      SHOW: begin
        if (!disp_en) begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) state_d = GAP;
          else                idx_d   = next_idx;
        end
      end
      GAP: begin
        if (!disp_en) begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = SHOW;
          idx_d   = next_idx;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    act_vld_d  = act_vld_q;
    pend_vld_d = pend_vld_q;
    if (state_q == OFF) begin
      if (load_fire) begin
        active_d  = load_if.load_data;
        act_vld_d = 1'b1;
      end
    end else begin
      if (transfer) begin
        active_d   = pending_q;
        pend_vld_d = 1'b0;
      end
      if (load_fire) begin
        pending_d  = load_if.load_data;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so they line up with the state they describe.
  assign nib        = active_d[{idx_d, 2'b00} +: 4];
  assign upper_zero = ((active_d >> {idx_d, 2'b00}) == '0);

  always_comb begin
    den_d = '0;
    bcd_d = '0;
    if (state_d == SHOW) begin
      den_d = NUM_DIGITS'(1) << idx_d;
      bcd_d = (blank_lz && idx_d != '0 && upper_zero) ? 4'hF : nib;
    end else if (state_d == GAP) begin
      bcd_d = bcd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      idx_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      act_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
      den_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      act_vld_q  <= act_vld_d;
      pend_vld_q <= pend_vld_d;
      bcd_q      <= bcd_d;
      den_q      <= den_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign digit_en   = den_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with 4 digits, 4 show cycles and 2 gap cycles per digit.
module tb_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int SC    = 4;
  localparam int GC    = 2;
  localparam int FRAME = ND * (SC + GC);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          disp_en  = 1'b0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_en;
  logic          frame_done;
  logic          ok;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SHOW_CYCLES(SC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_en   (disp_en),
    .blank_lz  (blank_lz),
    .load_if   (lif),
    .bcd_out   (bcd_out),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: display position is a frame time t in 0..FRAME-1; digit = t/(SC+GC), lit while t%(SC+GC) < SC.
  typedef struct packed {
    logic        on;
    logic [7:0]  t;
    logic [15:0] act;
    logic [15:0] pend;
    logic        av;
    logic        pv;
    logic [3:0]  den;
    logic [3:0]  bcd;
  } model_t;

  model_t m = '0;

  function automatic model_t step(input model_t c, input logic en, input logic blz,
                                  input logic lv, input logic [15:0] ld);
    model_t      n = c;
    logic        bnd, rdy, fire;
    int          d, ph;
    logic [15:0] upper;
    bnd  = c.on && (c.t == 8'(FRAME - 1));
    rdy  = !c.on || !c.pv || bnd;
    fire = lv && rdy;
    if (!c.on) begin
      if (en && c.av) begin
        n.on = 1'b1;
        n.t  = 8'd0;
      end
      if (fire) begin
        n.act = ld;
        n.av  = 1'b1;
      end
    end else begin
      if (c.pv && (bnd || !en)) begin
        n.act = c.pend;
        n.pv  = 1'b0;
      end
      if (fire) begin
        n.pend = ld;
        n.pv   = 1'b1;
      end
      if (!en) begin
        n.on = 1'b0;
        n.t  = 8'd0;
      end else begin
        n.t = bnd ? 8'd0 : c.t + 8'd1;
      end
    end
    n.den = '0;
    if (!n.on) begin
      n.bcd = '0;
    end else begin
      d  = int'(n.t) / (SC + GC);
      ph = int'(n.t) % (SC + GC);
      if (ph < SC) begin
        upper = n.act >> (4 * d);
        n.den = 4'(1 << d);
        n.bcd = (blz && d > 0 && upper == 16'h0) ? 4'hF : upper[3:0];
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, disp_en, blank_lz, lif.load_valid, lif.load_data);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("digit_en", 32'(digit_en), 32'(m.den));
    check("bcd_out", 32'(bcd_out), 32'(m.bcd));
    check("frame_done", 32'(frame_done), 32'(m.on && m.t == 8'(FRAME - 1)));
    check("load_ready", 32'(lif.load_ready), 32'(!m.on || !m.pv || m.t == 8'(FRAME - 1)));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input int max_wait, output logic acc);
    logic r;
    acc = 1'b0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    for (int i = 0; i < max_wait && !acc; i++) begin
      r = lif.load_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1'b1;
    end
    lif.load_valid = 1'b0;
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    cyc(3);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_ready", 32'(lif.load_ready), 32'h1);
    rst_n = 1'b1;

    load(16'h1234, 4, ok);
    check("load_1234", 32'(ok), 32'h1);
    disp_en = 1'b1;
    cyc(1);
    check("f1_d0_en", 32'(digit_en), 32'b0001);
    check("f1_d0_bcd", 32'(bcd_out), 32'h4);
    cyc(4);
    check("f1_gap_en", 32'(digit_en), 32'h0);
    check("f1_gap_bcd_held", 32'(bcd_out), 32'h4);
    cyc(2);
    check("f1_d1_en", 32'(digit_en), 32'b0010);
    check("f1_d1_bcd", 32'(bcd_out), 32'h3);
    cyc(17);
    check("f1_frame_done", 32'(frame_done), 32'h1);
    cyc(1);
    check("f2_frame_done_low", 32'(frame_done), 32'h0);
    check("f2_d0_en", 32'(digit_en), 32'b0001);

    cyc(3);
    load(16'h5678, 4, ok);
    check("load_5678", 32'(ok), 32'h1);
    check("ready_blocked", 32'(lif.load_ready), 32'h0);
    load(16'h9999, 40, ok);
    check("load_9999_at_boundary", 32'(ok), 32'h1);
    check("f3_d0_bcd_5678", 32'(bcd_out), 32'h8);
    check("f3_ready_low", 32'(lif.load_ready), 32'h0);
    cyc(FRAME);
    check("f4_d0_bcd_9999", 32'(bcd_out), 32'h9);
    check("f4_ready_high", 32'(lif.load_ready), 32'h1);

    blank_lz = 1'b1;
    load(16'h0070, 4, ok);
    check("load_0070", 32'(ok), 32'h1);
    cyc(FRAME - 1);
    check("lz_d0", 32'(bcd_out), 32'h0);
    cyc(6);
    check("lz_d1", 32'(bcd_out), 32'h7);
    cyc(6);
    check("lz_d2_en", 32'(digit_en), 32'b0100);
    check("lz_d2", 32'(bcd_out), 32'hF);
    cyc(6);
    check("lz_d3", 32'(bcd_out), 32'hF);
    cyc(6);
    blank_lz = 1'b0;
    cyc(12);
    check("nolz_d2", 32'(bcd_out), 32'h0);
    cyc(6);
    check("nolz_d3", 32'(bcd_out), 32'h0);

    blank_lz = 1'b1;
    load(16'hA0B0, 4, ok);
    check("load_a0b0", 32'(ok), 32'h1);
    cyc(5);
    check("hex_d0", 32'(bcd_out), 32'h0);
    cyc(6);
    check("hex_d1", 32'(bcd_out), 32'hB);
    cyc(6);
    check("hex_d2_inner_zero", 32'(bcd_out), 32'h0);
    cyc(6);
    check("hex_d3", 32'(bcd_out), 32'hA);

    cyc(6 + 13);
    load(16'h0003, 4, ok);
    check("load_0003", 32'(ok), 32'h1);
    disp_en = 1'b0;
    cyc(1);
    check("drop_digit_en", 32'(digit_en), 32'h0);
    check("drop_bcd", 32'(bcd_out), 32'h0);
    check("drop_ready", 32'(lif.load_ready), 32'h1);
    cyc(3);
    disp_en = 1'b1;
    cyc(1);
    check("reen_d0_en", 32'(digit_en), 32'b0001);
    check("reen_d0_bcd", 32'(bcd_out), 32'h3);

    cyc(4);
    rst_n = 1'b0;
    #1;
    check("arst_digit_en", 32'(digit_en), 32'h0);
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    check("arst_ready", 32'(lif.load_ready), 32'h1);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("post_rst_dark", 32'(digit_en), 32'h0);
    load(16'h0042, 4, ok);
    check("load_0042", 32'(ok), 32'h1);
    cyc(1);
    check("post_rst_d0_en", 32'(digit_en), 32'b0001);
    check("post_rst_d0_bcd", 32'(bcd_out), 32'h2);
    cyc(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SHOW_CYCLES, default 1000: clk cycles each digit is driven, range >= 1.
REQ-003 Parameter GAP_CYCLES, default 8: anti-ghost blank cycles after each digit; 0 disables the gap.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 disp_en  input  1  display enable; low forces the display off.
REQ-007 blank_lz  input  1  leading-zero blanking enable.
REQ-008 load_valid  input  1  load request; load_data is valid when high.
REQ-009 load_data  input  4*NUM_DIGITS  BCD nibbles; nibble i = bits [4i+3:4i], digit 0 least significant.
REQ-010 load_ready  output  1  block can accept load_data this cycle.
REQ-011 bcd_out  output  4  BCD code for the downstream BCD-to-7-segment decoder, registered.
REQ-012 digit_en  output  NUM_DIGITS  one-hot active-high digit select, registered.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-014 The block SHALL hold an active register (displayed value), a pending register, and flags active_valid and pending_valid.
REQ-015 A load SHALL be accepted on any cycle with load_valid and load_ready both high; the sender holds load_data until accepted.
REQ-016 The FSM SHALL have states OFF, SHOW and GAP, and SHALL track a digit index idx running 0..NUM_DIGITS-1.
REQ-017 In OFF, load_ready SHALL be 1, an accepted load SHALL write the active register directly, and active_valid SHALL be set.
REQ-018 OFF->SHOW with idx=0 SHALL occur when disp_en=1 and active_valid=1; digit_en and bcd_out SHALL be valid from the next cycle.
REQ-019 SHOW SHALL last exactly SHOW_CYCLES cycles with digit_en = 1<<idx and bcd_out = displayed nibble idx.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with digit_en = 0 and bcd_out held; with GAP_CYCLES=0, SHOW SHALL advance directly to the next digit.
REQ-021 After the GAP of idx=NUM_DIGITS-1, idx SHALL wrap to 0; that final cycle is the frame boundary, and frame_done SHALL be 1 in it.
REQ-022 Outside OFF, load_ready SHALL be !pending_valid OR frame boundary.
REQ-023 Outside OFF, an accepted load SHALL write the pending register and set pending_valid.
REQ-024 At the frame-boundary edge, pending SHALL be copied to active and pending_valid cleared, unless a new load is accepted in the same cycle.
REQ-025 On a simultaneous frame-boundary transfer and load accept, old pending SHALL go to active, the new data to pending, and pending_valid SHALL remain 1.
REQ-026 If disp_en falls in SHOW or GAP, the next cycle SHALL be OFF with digit_en=0, idx=0, and any pending data transferred to active.
REQ-027 With blank_lz=1, digit i (i>0) SHALL output bcd_out=4'hF (decoder blanks) when active nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never blanked.
REQ-028 Nibbles above 9 SHALL be passed to bcd_out unchanged.
REQ-029 The cycle counter SHALL be wide enough for max(SHOW_CYCLES, GAP_CYCLES) and SHALL restart at 0 on each state entry.

Reset
REQ-030 While rst_n=0: state OFF; idx, counter, active and pending registers, active_valid and pending_valid all 0; digit_en=0, bcd_out=0, frame_done=0, load_ready=1.
REQ-031 Reset assertion mid-frame SHALL take effect immediately, with no completion of the current digit or pending transfer.

Verification (NUM_DIGITS=4, SHOW_CYCLES=4, GAP_CYCLES=2)
REQ-032 Reset release, load 16'h1234, disp_en=1 -> digit_en 0001/0010/0100/1000 for 4 cycles each with bcd_out 4/3/2/1, 2 zero cycles between digits, frame_done every 24 cycles.
REQ-033 Load 16'h5678 mid-frame, then attempt 16'h9999 before the boundary -> second load sees load_ready=0; 5678 is displayed from the next frame; 9999 is accepted at the boundary and displayed the frame after.
REQ-034 Load 16'h0070 with blank_lz=1 -> bcd_out per digit 0,7,F,F; with blank_lz=0 -> 0,7,0,0.
REQ-035 disp_en dropped during SHOW of digit 2 -> digit_en=0 the next cycle; on re-enable, the scan restarts at digit 0.
REQ-036 rst_n pulsed low during GAP -> all outputs 0 asynchronously; after release, no display until a new load with disp_en=1.
